// File: rtl/wifi_tx_preamble_gen.sv
// wifi_tx_preamble_gen: 802.11a/g short/long training preamble generator with edge windowing and ready/valid output
module wifi_tx_preamble_gen #(
  parameter int DATA_W        = 12,
  parameter int SHORT_REPEATS = 10,
  parameter int LONG_REPEATS  = 2,
  parameter int GI2_LEN       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              abort,
  input  logic              out_ready,
  output logic              valid_out,
  output logic [DATA_W-1:0] pre_re,
  output logic [DATA_W-1:0] pre_im,
  output logic              busy,
  output logic              done
);
  localparam int NS = 16 * SHORT_REPEATS;
  localparam int G  = 64 - GI2_LEN;
  localparam int NL = GI2_LEN + 64 * LONG_REPEATS;
  localparam int CW = $clog2(NS + NL + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   n_q, n_d, last;
  logic [1:0]      mode_q, mode_d;
  logic [23:0]     sv, lv;
  logic            is_short, junc, half;
  int              m_i;

  function automatic logic [23:0] short_rom(input logic [3:0] k);
    case (k)
      4'd0, 4'd8:   short_rom = {12'h018, 12'h018};
      4'd1, 4'd7:   short_rom = {12'hFBC, 12'h001};
      4'd2, 4'd6:   short_rom = {12'hFF9, 12'hFD8};
      4'd3, 4'd5:   short_rom = {12'h049, 12'hFF9};
      4'd4:         short_rom = {12'h02F, 12'h000};
      4'd9, 4'd15:  short_rom = {12'h001, 12'hFBC};
      4'd10, 4'd14: short_rom = {12'hFD8, 12'hFF9};
      4'd11, 4'd13: short_rom = {12'hFF9, 12'h049};
      default:      short_rom = {12'h000, 12'h02F};
    endcase
  endfunction

  // The long symbol is conjugate-symmetric, so only indices 0..32 are stored.
  function automatic logic [23:0] long_rom(input logic [5:0] k);
    logic [5:0]  j;
    logic [23:0] v;
    j = k > 6'd32 ? 6'd0 - k : k;
    case (j)
      6'd0:    v = {12'h050, 12'h000};
      6'd1:    v = {12'hFFD, 12'hFC3};
      6'd2:    v = {12'h014, 12'hFC7};
      6'd3:    v = {12'h032, 12'h02A};
      6'd4:    v = {12'h00B, 12'h00E};
      6'd5:    v = {12'h01F, 12'hFD3};
      6'd6:    v = {12'hFC5, 12'hFE4};
      6'd7:    v = {12'hFED, 12'hFCA};
      6'd8:    v = {12'h032, 12'hFF3};
      6'd9:    v = {12'h01B, 12'h002};
      6'd10:   v = {12'h001, 12'hFC5};
      6'd11:   v = {12'hFBA, 12'hFE8};
      6'd12:   v = {12'h00C, 12'hFE2};
      6'd13:   v = {12'h01E, 12'hFF8};
      6'd14:   v = {12'hFF5, 12'h052};
      6'd15:   v = {12'h03D, 12'hFFE};
      6'd16:   v = {12'h020, 12'hFE0};
      6'd17:   v = {12'h013, 12'h032};
      6'd18:   v = {12'hFE3, 12'h014};
      6'd19:   v = {12'hFBD, 12'h021};
      6'd20:   v = {12'h02A, 12'h02F};
      6'd21:   v = {12'h024, 12'h007};
      6'd22:   v = {12'hFE1, 12'h029};
      6'd23:   v = {12'hFE3, 12'hFF5};
      6'd24:   v = {12'hFEE, 12'hFB3};
      6'd25:   v = {12'hFC2, 12'hFF7};
      6'd26:   v = {12'hFBF, 12'hFF5};
      6'd27:   v = {12'h026, 12'hFDA};
      6'd28:   v = {12'hFFE, 12'h01C};
      6'd29:   v = {12'hFD1, 12'h03B};
      6'd30:   v = {12'h02F, 12'h036};
      6'd31:   v = {12'h006, 12'h032};
      default: v = {12'hFB0, 12'h000};
    endcase
    long_rom = k > 6'd32 ? {v[23:12], 12'h000 - v[11:0]} : v;
  endfunction

  function automatic logic signed [DATA_W:0] scale(input logic [11:0] v);
    scale = $signed({{(DATA_W-11){v[11]}}, v}) <<< (DATA_W - 12);
  endfunction

  // Sum is one bit wider than the output so the junction average cannot overflow.
  function automatic logic [DATA_W-1:0] pick(input logic [11:0] s, input logic [11:0] l,
                                             input logic use_s, input logic both, input logic hv);
    logic signed [DATA_W:0] sum;
    sum  = both ? scale(s) + scale(l) : use_s ? scale(s) : scale(l);
    pick = hv ? DATA_W'(sum >>> 1) : DATA_W'(sum);
  endfunction

  assign last = mode_q == 2'b01 ? CW'(NS) : mode_q == 2'b00 ? CW'(NL) : CW'(NS + NL);

  // State, sample index and latched mode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      mode_q  <= mode_d;
    end
  end

  // Next state: abort dominates, then start acceptance, then transfers
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    mode_d  = mode_q;
    if (abort) begin
      state_d = IDLE;
    end else if (state_q == IDLE && start && mode != 2'b11) begin
      state_d = RUN;
      n_d     = '0;
      mode_d  = mode;
    end else if (state_q == RUN && out_ready) begin
      n_d     = n_q + 1'b1;
      state_d = n_q == last ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  // Outputs: sample n is selected from the ROMs and windowed at the edges and junction
  always_comb begin
    m_i       = mode_q == 2'b10 ? int'(n_q) - NS : int'(n_q);
    sv        = short_rom(n_q[3:0]);
    lv        = long_rom(6'(m_i < GI2_LEN ? m_i + G : m_i - GI2_LEN));
    is_short  = mode_q == 2'b01 || (mode_q == 2'b10 && int'(n_q) < NS);
    junc      = mode_q == 2'b10 && int'(n_q) == NS;
    half      = n_q == '0 || n_q == last || junc;
    valid_out = state_q == RUN;
    busy      = state_q == RUN;
    done      = state_q == DONE;
    pre_re    = valid_out ? pick(sv[23:12], lv[23:12], is_short, junc, half) : '0;
    pre_im    = valid_out ? pick(sv[11:0], lv[11:0], is_short, junc, half) : '0;
  end
endmodule

// File: tb/tb_wifi_tx_preamble_gen.sv
// tb_wifi_tx_preamble_gen: directed scenario bench for the preamble generator
module tb_wifi_tx_preamble_gen;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic        valid_out, busy, done;
  logic [11:0] pre_re, pre_im;

  int total = 0;
  int passed = 0;
  logic [11:0] cap_re[0:511], cap_im[0:511];
  logic [11:0] ref_re[0:511], ref_im[0:511];
  logic [11:0] sref_re[0:511], sref_im[0:511];
  int ncap, done_cyc, busy_cnt, stable_err, first_valid, errs, cnt;
  bit done_clean, seen_done;

  wifi_tx_preamble_gen dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
    .out_ready(out_ready), .valid_out(valid_out), .pre_re(pre_re), .pre_im(pre_im),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic run_seq(input logic [1:0] md, input bit bp, input int restart_at, input int max_cyc);
    bit prev_stall;
    logic [11:0] pr, pi;
    @(negedge clk);
    mode = md;
    start = 1'b1;
    out_ready = 1'b1;
    ncap = 0; done_cyc = -1; busy_cnt = 0; stable_err = 0; first_valid = -1;
    done_clean = 1'b0; prev_stall = 1'b0; pr = '0; pi = '0;
    for (int cyc = 1; cyc <= max_cyc && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (ncap == restart_at && valid_out) begin
        start = 1'b1;
        mode = 2'b01;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = cyc;
        done_clean = !valid_out && !busy && pre_re == 12'h000 && pre_im == 12'h000;
      end
      if (valid_out && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!valid_out || pre_re !== pr || pre_im !== pi)) stable_err++;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = valid_out && !out_ready;
      pr = pre_re;
      pi = pre_im;
      if (valid_out && out_ready && ncap < 512) begin
        cap_re[ncap] = pre_re;
        cap_im[ncap] = pre_im;
        ncap++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    #1;
    total++; if (valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_out); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (pre_re !== 12'h000) $display("FAIL reset_re got %h want 000", pre_re); else passed++;
    total++; if (pre_im !== 12'h000) $display("FAIL reset_im got %h want 000", pre_im); else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_long;
    run_seq(2'b00, 1'b0, -1, 400);
    total++; if (ncap !== 161) $display("FAIL long_count got %0d want 161", ncap); else passed++;
    total++; if (first_valid !== 1) $display("FAIL long_latency got %0d want 1", first_valid); else passed++;
    total++; if (done_cyc !== 162) $display("FAIL long_done_cycle got %0d want 162", done_cyc); else passed++;
    total++; if (busy_cnt !== 161) $display("FAIL long_busy_cycles got %0d want 161", busy_cnt); else passed++;
    total++; if (!done_clean) $display("FAIL long_done_outputs got dirty want cleared"); else passed++;
    total++; if (cap_re[0] !== 12'hFD8 || cap_im[0] !== 12'h000) $display("FAIL long_s0 got %h/%h want fd8/000", cap_re[0], cap_im[0]); else passed++;
    total++; if (cap_re[32] !== 12'h050 || cap_im[32] !== 12'h000) $display("FAIL long_s32 got %h/%h want 050/000", cap_re[32], cap_im[32]); else passed++;
    total++; if (cap_re[33] !== 12'hFFD || cap_im[33] !== 12'hFC3) $display("FAIL long_s33 got %h/%h want ffd/fc3", cap_re[33], cap_im[33]); else passed++;
    total++; if (cap_re[160] !== 12'h028 || cap_im[160] !== 12'h000) $display("FAIL long_s160 got %h/%h want 028/000", cap_re[160], cap_im[160]); else passed++;
    errs = 0;
    for (int i = 96; i < 160; i++) if (cap_re[i] !== cap_re[i-64] || cap_im[i] !== cap_im[i-64]) errs++;
    total++; if (errs !== 0) $display("FAIL long_period64 diffs=%0d want 0", errs); else passed++;
    for (int i = 0; i < 161; i++) begin
      ref_re[i] = cap_re[i];
      ref_im[i] = cap_im[i];
    end
  endtask

  task automatic test_short;
    run_seq(2'b01, 1'b0, -1, 400);
    total++; if (ncap !== 161) $display("FAIL short_count got %0d want 161", ncap); else passed++;
    total++; if (done_cyc !== 162) $display("FAIL short_done_cycle got %0d want 162", done_cyc); else passed++;
    total++; if (cap_re[0] !== 12'h00C || cap_im[0] !== 12'h00C) $display("FAIL short_s0 got %h/%h want 00c/00c", cap_re[0], cap_im[0]); else passed++;
    total++; if (cap_re[16] !== 12'h018 || cap_im[16] !== 12'h018) $display("FAIL short_s16 got %h/%h want 018/018", cap_re[16], cap_im[16]); else passed++;
    total++; if (cap_re[160] !== 12'h00C || cap_im[160] !== 12'h00C) $display("FAIL short_s160 got %h/%h want 00c/00c", cap_re[160], cap_im[160]); else passed++;
    errs = 0;
    for (int i = 17; i < 160; i++) if (cap_re[i] !== cap_re[i-16] || cap_im[i] !== cap_im[i-16]) errs++;
    total++; if (errs !== 0) $display("FAIL short_period16 diffs=%0d want 0", errs); else passed++;
    for (int i = 0; i < 161; i++) begin
      sref_re[i] = cap_re[i];
      sref_im[i] = cap_im[i];
    end
  endtask

  task automatic test_full;
    run_seq(2'b10, 1'b0, -1, 600);
    total++; if (ncap !== 321) $display("FAIL full_count got %0d want 321", ncap); else passed++;
    total++; if (done_cyc !== 322) $display("FAIL full_done_cycle got %0d want 322", done_cyc); else passed++;
    total++; if (cap_re[0] !== 12'h00C || cap_im[0] !== 12'h00C) $display("FAIL full_s0 got %h/%h want 00c/00c", cap_re[0], cap_im[0]); else passed++;
    total++; if (cap_re[160] !== 12'hFE4 || cap_im[160] !== 12'h00C) $display("FAIL full_junction got %h/%h want fe4/00c", cap_re[160], cap_im[160]); else passed++;
    total++; if (cap_re[192] !== 12'h050 || cap_im[192] !== 12'h000) $display("FAIL full_s192 got %h/%h want 050/000", cap_re[192], cap_im[192]); else passed++;
    total++; if (cap_re[320] !== 12'h028 || cap_im[320] !== 12'h000) $display("FAIL full_s320 got %h/%h want 028/000", cap_re[320], cap_im[320]); else passed++;
    errs = 0;
    for (int i = 0; i < 160; i++) if (cap_re[i] !== sref_re[i] || cap_im[i] !== sref_im[i]) errs++;
    for (int m = 1; m <= 160; m++) if (cap_re[160+m] !== ref_re[m] || cap_im[160+m] !== ref_im[m]) errs++;
    total++; if (errs !== 0) $display("FAIL full_segments diffs=%0d want 0", errs); else passed++;
  endtask

  task automatic test_backpressure;
    run_seq(2'b00, 1'b1, -1, 3000);
    total++; if (ncap !== 161) $display("FAIL bp_count got %0d want 161", ncap); else passed++;
    total++; if (done_cyc < 0) $display("FAIL bp_done got timeout want pulse"); else passed++;
    total++; if (stable_err !== 0) $display("FAIL bp_stable unstable=%0d want 0", stable_err); else passed++;
    errs = 0;
    for (int i = 0; i < 161; i++) if (cap_re[i] !== ref_re[i] || cap_im[i] !== ref_im[i]) errs++;
    total++; if (errs !== 0) $display("FAIL bp_sequence diffs=%0d want 0", errs); else passed++;
    total++; if (cap_re[0] !== 12'hFD8 || cap_re[160] !== 12'h028) $display("FAIL bp_edges got %h/%h want fd8/028", cap_re[0], cap_re[160]); else passed++;
  endtask

  task automatic test_abort;
    @(negedge clk);
    mode = 2'b10;
    start = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid_out && cnt == 50) break;
      if (valid_out) cnt++;
    end
    total++; if (cnt !== 50) $display("FAIL abort_reach got %0d want 50", cnt); else passed++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (valid_out !== 1'b0 || busy !== 1'b0) $display("FAIL abort_idle got valid=%b busy=%b want 0/0", valid_out, busy); else passed++;
    total++; if (pre_re !== 12'h000 || pre_im !== 12'h000) $display("FAIL abort_outputs got %h/%h want 000/000", pre_re, pre_im); else passed++;
    seen_done = done;
    repeat (10) begin
      @(negedge clk);
      seen_done |= done | valid_out;
    end
    total++; if (seen_done) $display("FAIL abort_no_done got activity want none"); else passed++;
    run_seq(2'b00, 1'b0, -1, 400);
    total++; if (cap_re[0] !== 12'hFD8 || ncap !== 161) $display("FAIL abort_restart got %h n=%0d want fd8 n=161", cap_re[0], ncap); else passed++;
  endtask

  task automatic test_reserved_and_restart;
    run_seq(2'b11, 1'b0, -1, 20);
    total++; if (ncap !== 0 || done_cyc !== -1) $display("FAIL reserved_activity got n=%0d done=%0d want 0/-1", ncap, done_cyc); else passed++;
    total++; if (busy_cnt !== 0) $display("FAIL reserved_busy got %0d want 0", busy_cnt); else passed++;
    run_seq(2'b00, 1'b0, 10, 400);
    errs = 0;
    for (int i = 0; i < 161; i++) if (cap_re[i] !== ref_re[i] || cap_im[i] !== ref_im[i]) errs++;
    total++; if (ncap !== 161 || errs !== 0) $display("FAIL run_start_ignored got n=%0d diffs=%0d want 161/0", ncap, errs); else passed++;
    total++; if (done_cyc !== 162) $display("FAIL run_start_done got %0d want 162", done_cyc); else passed++;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    mode = 2'b00;
    start = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid_out && cnt == 80) break;
      if (valid_out) cnt++;
    end
    total++; if (cnt !== 80 || pre_re !== ref_re[80]) $display("FAIL areset_reach got n=%0d re=%h want 80 re=%h", cnt, pre_re, ref_re[80]); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (valid_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL areset_flags got %b%b%b want 000", valid_out, busy, done); else passed++;
    total++; if (pre_re !== 12'h000 || pre_im !== 12'h000) $display("FAIL areset_outputs got %h/%h want 000/000", pre_re, pre_im); else passed++;
    @(negedge clk);
    reset = 1'b1;
    run_seq(2'b00, 1'b0, -1, 400);
    total++; if (ncap !== 161 || cap_re[0] !== 12'hFD8) $display("FAIL areset_replay got n=%0d re=%h want 161 fd8", ncap, cap_re[0]); else passed++;
  endtask

  initial begin
    test_reset;
    test_long;
    test_short;
    test_full;
    test_backpressure;
    test_abort;
    test_reserved_and_restart;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wifi_tx_preamble_gen.md
Name: wifi_tx_preamble_gen

Overview:
Parametrised 802.11a/g TX preamble generator. Emits short-only, long-only or full (short + long) training sequences from internal short/long ROMs, with 802.11a boundary windowing (halved edge samples, averaged junction sample). Sits ahead of the TX framing mux. Adds start/mode control, ready/valid backpressure, abort and a busy flag.

Parameters:
DATA_W, 12, output sample width in two's complement; must be >= 12. ROM values are sign-extended, then left-shifted by DATA_W-12.
SHORT_REPEATS, 10, number of 16-sample short-symbol periods.
LONG_REPEATS, 2, number of 64-sample long-symbol periods.
GI2_LEN, 32, long guard length in samples; must be 1..64.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  2  00 long-only, 01 short-only, 10 full, 11 reserved; latched at start
abort  in  1  synchronous abort; returns to IDLE
out_ready  in  1  downstream ready
valid_out  out  1  pre_re/pre_im valid
pre_re  out  DATA_W  sample, real part
pre_im  out  DATA_W  sample, imaginary part
busy  out  1  high from the cycle after an accepted start until return to IDLE
done  out  1  one-cycle pulse after the final sample transfer

Behaviour:
- Reset (async, reset=0): state IDLE; valid_out=0, pre_re=0, pre_im=0, busy=0, done=0; sample counter=0.
- ROMs: S[0..15] holds one short-symbol period. S[0]=0x018+j0x018 at 12 bit. L[0..63] holds one long-symbol period. L[0]=0x050+j0, L[1]=0xFFD+j0xFC3, L[32]=0xFB0+j0. All arithmetic is signed; >>>1 means arithmetic shift right (floor). Sum width is DATA_W+1 before the shift.
- Let NS=16*SHORT_REPEATS, G=64-GI2_LEN, NL=GI2_LEN+64*LONG_REPEATS.
- Short-only, length NS+1:
  - n=0: S[0]>>>1
  - n=1..NS-1: S[n mod 16]
  - n=NS: S[0]>>>1
- Long-only, length NL+1:
  - n=0: L[G]>>>1
  - n=1..GI2_LEN-1: L[G+n]
  - n=GI2_LEN..NL-1: L[(n-GI2_LEN) mod 64]
  - n=NL: L[0]>>>1
- Full, length NS+NL+1:
  - n=0..NS-1: as short-only.
  - n=NS: (S[0]+L[G])>>>1 (junction).
  - Remaining samples: long-only indices offset by NS, excluding the long n=0 sample.
  - n=NS+NL: L[0]>>>1.
- States: IDLE -> RUN -> DONE -> IDLE.
  - IDLE: valid_out=0 and outputs held at 0. On start=1 with mode!=11: latch mode, n=0, go to RUN.
  - mode=11: start is ignored; stay IDLE; no valid_out, no done.
  - RUN: valid_out=1 with sample n presented. Transfer occurs when valid_out&&out_ready. On transfer, n increments and the next sample is presented the following cycle, so back-to-back transfers run at one sample per cycle.
  - RUN with out_ready=0: pre_re, pre_im and valid_out hold stable.
  - Last transfer: go to DONE; valid_out=0 and outputs clear to 0 the next cycle.
  - DONE: done=1 for exactly one cycle; busy=0; go to IDLE. A start in DONE is ignored.
- Latency: first sample valid the cycle after start (start at cycle k -> valid_out=1 at k+1).
- start while RUN is ignored; mode changes during RUN are ignored.
- abort=1 in any state: next cycle IDLE, valid_out=0, outputs 0, busy=0, no done pulse. abort takes priority over a simultaneous transfer or start.
- Async reset mid-sequence: immediate return to reset values. A new start after release replays from n=0.
- Counter width is clog2(NS+NL+2). No wrap: the last index is compared explicitly.

Test Plan:
1. Reset, then start with mode=00 and out_ready=1 continuously -> 161 contiguous valid samples. Sample0=0xFD8+j0, sample32=0x050+j0, sample33=0xFFD+j0xFC3, sample160=0x028+j0. done pulses at cycle 162 after start; busy is high for 161 cycles.
2. mode=01 with defaults -> 161 samples. Sample0=0x00C+j0x00C, sample16=S[0]=0x018+j0x018, sample160=0x00C+j0x00C. Check periodicity of 16 across samples 1..159.
3. mode=10 -> 321 samples. Sample160=(0x018+0xFB0)>>>1=0xFE4, imag 0x00C. Sample192=0x050. Sample320=0x028.
4. Backpressure: mode=00, toggle out_ready pseudo-randomly (~50%) -> the sequence is identical to scenario 1. pre_re/pre_im stay stable while valid_out=1 and out_ready=0. Exactly 161 transfers.
5. abort asserted at transfer 50 of mode=10 -> valid_out=0 the next cycle, no done. A following start with mode=00 outputs 0xFD8 first.
6. start with mode=11 -> no valid_out, no done, busy stays 0. Start asserted during RUN is ignored. Async reset at sample 80 clears all outputs within the same cycle.
